// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches over req/ready + rvalid (one outstanding), feeds IF/ID.
// Perf counters exist only when IFETCH_PERF_EN is defined; otherwise tied to zero.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             pc_src,
  input  logic [31:0]      pc_branch,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_pc,
  output logic [31:0]      IF_ID_inst,
  output logic [4:0]       IF_ID_rs1,
  output logic [4:0]       IF_ID_rs2,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] perf_fetch_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [4:0]  ifid_rs1_q, ifid_rs1_d;
  logic [4:0]  ifid_rs2_q, ifid_rs2_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redir;
  logic        delivered;
  logic        req;
  logic [31:0] target;
  logic        unused_pc_branch_lsb;

  assign unused_pc_branch_lsb = ^pc_branch[1:0];

  always_comb begin
    redir     = pc_src & ~stall;
    target    = {pc_branch[31:2], 2'b00};
    delivered = (state_q == S_WAIT) & imem_rvalid & ~redir;
    state_d   = state_q;
    pc_d      = pc_q;
    fpc_d     = fpc_q;
    req       = 1'b0;
    case (state_q)
      S_REQ: begin
        req = ~hold_valid_q & ~redir;
        if (redir) begin
          pc_d = target;
        end else if (req && imem_ready) begin
          pc_d    = pc_q + 32'd4;
          fpc_d   = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (redir) begin
            pc_d = target;
          end else begin
            // Re-request in the response cycle for back-to-back fetches.
            req = ~stall & ~hold_valid_q;
            if (req && imem_ready) begin
              pc_d    = pc_q + 32'd4;
              fpc_d   = pc_q;
              state_d = S_WAIT;
            end
          end
        end else if (redir) begin
          pc_d    = target;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redir) pc_d = target;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req  = req & ~reset;
  assign imem_addr = pc_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_rs1_d   = ifid_rs1_q;
    ifid_rs2_d   = ifid_rs2_q;
    ifid_valid_d = ifid_valid_q;
    if (!stall) begin
      hold_valid_d = 1'b0;
      if (!redir && hold_valid_q) begin
        ifid_pc_d    = hold_pc_q;
        ifid_inst_d  = hold_inst_q;
        ifid_valid_d = 1'b1;
      end else if (delivered) begin
        ifid_pc_d    = fpc_q;
        ifid_inst_d  = imem_rdata;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
      end
      ifid_rs1_d = ifid_inst_d[19:15];
      ifid_rs2_d = ifid_inst_d[24:20];
    end else if (delivered) begin
      // IF/ID is frozen, so park the response until the stall lifts.
      hold_valid_d = 1'b1;
      hold_pc_d    = fpc_q;
      hold_inst_d  = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      fpc_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_inst_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_rs1_q   <= '0;
      ifid_rs2_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_rs1_q   <= ifid_rs1_d;
      ifid_rs2_q   <= ifid_rs2_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_inst  = ifid_inst_q;
  assign IF_ID_rs1   = ifid_rs1_q;
  assign IF_ID_rs2   = ifid_rs2_q;
  assign IF_ID_valid = ifid_valid_q;

`ifdef IFETCH_PERF_EN
  logic             fetch_load;
  logic             bubble_load;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign fetch_load  = ~stall & ~redir & (hold_valid_q | delivered);
  assign bubble_load = ~stall & ~fetch_load;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + CNT_W'(fetch_load);
    bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model plus scoreboard of expected IF/ID loads.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XMSK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, pc_src, imem_ready, imem_rvalid;
  logic [31:0] pc_branch, imem_rdata, imem_addr;
  logic        imem_req, IF_ID_valid;
  logic [31:0] IF_ID_pc, IF_ID_inst;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_rs1(IF_ID_rs1),
    .IF_ID_rs2(IF_ID_rs2), .IF_ID_valid(IF_ID_valid),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs for the next cycle; applied by step() at the falling edge.
  logic        t_reset = 1'b1, t_stall = 1'b0, t_pc_src = 1'b0, t_ready = 1'b1;
  logic [31:0] t_branch = '0;
  int          mem_delay = 1;

  int          cyc = 0;
  logic        out_vld = 1'b0, out_stale = 1'b0;
  logic [31:0] out_addr = '0;
  int          out_due = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc = '0;
  int          n_pop = 0, n_upd = 0;
  logic        prev_upd = 1'b0;

  task automatic step();
    logic        rv, rstale, redir;
    logic [31:0] ra;
    logic [63:0] e;
    @(negedge clk);
    cyc++;
    reset = t_reset; stall = t_stall; pc_src = t_pc_src;
    pc_branch = t_branch; imem_ready = t_ready;
    rv     = out_vld && (cyc == out_due);
    ra     = out_addr;
    rstale = out_stale;
    if (rv) out_vld = 1'b0;
    imem_rvalid = rv;
    imem_rdata  = rv ? (ra ^ XMSK) : $urandom;
    #1;
    if (reset) begin
      check_eq("req_in_reset", imem_req, 0);
      out_stale = 1'b1;
      sb_q.delete();
      exp_pc = '0; n_pop = 0; n_upd = 0; prev_upd = 1'b0;
    end else begin
      if (prev_upd) n_upd++;
      if (prev_upd && IF_ID_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("ifid_pc", IF_ID_pc, e[63:32]);
          check_eq("ifid_inst", IF_ID_inst, e[31:0]);
          check_eq("ifid_rs1", IF_ID_rs1, 32'(e[19:15]));
          check_eq("ifid_rs2", IF_ID_rs2, 32'(e[24:20]));
          n_pop++;
        end
      end
      redir = pc_src & ~stall;
      if (redir) begin
        out_stale = 1'b1;
        rstale    = 1'b1;
      end
      if (rv && !rstale) sb_q.push_back({ra, ra ^ XMSK});
      if (imem_req && imem_ready) begin
        check_eq("one_outstanding", out_vld, 0);
        check_eq("fetch_addr", imem_addr, exp_pc);
        exp_pc    = exp_pc + 32'd4;
        out_vld   = 1'b1;
        out_addr  = imem_addr;
        out_due   = cyc + mem_delay;
        out_stale = 1'b0;
      end
      if (redir) exp_pc = {pc_branch[31:2], 2'b00};
      prev_upd = ~stall;
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef IFETCH_PERF_EN
    check_eq({tag, "_fetch_cnt"}, perf_fetch_cnt, 32'(n_pop));
    check_eq({tag, "_bubble_cnt"}, perf_bubble_cnt, 32'(n_upd - n_pop));
`else
    check_eq({tag, "_fetch_cnt"}, perf_fetch_cnt, 0);
    check_eq({tag, "_bubble_cnt"}, perf_bubble_cnt, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"}, IF_ID_pc, 0);
    check_eq({tag, "_inst"}, IF_ID_inst, NOP);
    check_eq({tag, "_valid"}, IF_ID_valid, 0);
    check_eq({tag, "_rs1"}, IF_ID_rs1, 0);
    check_eq({tag, "_rs2"}, IF_ID_rs2, 0);
    check_eq({tag, "_addr"}, imem_addr, 0);
    check_eq({tag, "_perf_f"}, perf_fetch_cnt, 0);
    check_eq({tag, "_perf_b"}, perf_bubble_cnt, 0);
  endtask

  logic [31:0] f_pc, f_inst, a0;

  initial begin
    reset = 1'b1; stall = 1'b0; pc_src = 1'b0; pc_branch = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

    repeat (2) step();
    check_reset_outputs("rst");

    // Sequential fetch with single-cycle memory
    t_reset = 1'b0;
    step();
    check_eq("t1_req_N", imem_req, 1);
    check_eq("t1_addr_N", imem_addr, 0);
    step();
    check_eq("t1_valid_N1", IF_ID_valid, 0);
    step();
    check_eq("t1_valid_N2", IF_ID_valid, 1);
    check_eq("t1_pc_N2", IF_ID_pc, 0);
    step();
    check_eq("t1_pc_N3", IF_ID_pc, 4);
    repeat (6) step();
    check_perf("t1");

    // Stall three cycles while a response arrives
    t_stall = 1'b1;
    step();
    check_eq("t2_req_s1", imem_req, 0);
    f_pc = IF_ID_pc; f_inst = IF_ID_inst;
    for (int i = 2; i <= 3; i++) begin
      step();
      check_eq("t2_req_stalled", imem_req, 0);
      check_eq("t2_frozen_pc", IF_ID_pc, f_pc);
      check_eq("t2_frozen_inst", IF_ID_inst, f_inst);
    end
    t_stall = 1'b0;
    step();
    check_eq("t2_frozen_last", IF_ID_pc, f_pc);
    repeat (5) step();
    check_perf("t2");

    // Redirect while waiting; stale response arrives two cycles later
    mem_delay = 3;
    step();
    mem_delay = 1;
    t_pc_src = 1'b1; t_branch = 32'h100;
    step();
    t_pc_src = 1'b0;
    step();
    check_eq("t3_bubble_inst", IF_ID_inst, NOP);
    check_eq("t3_bubble_valid", IF_ID_valid, 0);
    check_eq("t3_drop_req", imem_req, 0);
    step();
    check_eq("t3_drop_rv_req", imem_req, 0);
    step();
    check_eq("t3_req_target", imem_req, 1);
    check_eq("t3_addr_target", imem_addr, 32'h100);
    repeat (2) step();
    check_eq("t3_ifid_pc", IF_ID_pc, 32'h100);
    check_eq("t3_ifid_valid", IF_ID_valid, 1);
    repeat (3) step();

    // Redirect coincides with rvalid; unaligned target is word-aligned
    t_pc_src = 1'b1; t_branch = 32'h203;
    step();
    t_pc_src = 1'b0;
    step();
    check_eq("t4_inst", IF_ID_inst, NOP);
    check_eq("t4_valid", IF_ID_valid, 0);
    check_eq("t4_addr", imem_addr, 32'h200);
    check_eq("t4_req", imem_req, 1);
    repeat (4) step();
    check_perf("t4");

    // Memory not ready for 5 cycles; pc_src under stall ignored
    t_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i >= 4) begin
        t_stall = 1'b1; t_pc_src = 1'b1; t_branch = 32'h300;
      end
      step();
      if (i == 1) a0 = imem_addr;
      check_eq("t5_req_held", imem_req, 1);
      check_eq("t5_addr_stable", imem_addr, a0);
      if (i >= 3) check_eq("t5_bubble", IF_ID_valid, 0);
    end
    t_ready = 1'b1; t_stall = 1'b0; t_pc_src = 1'b0;
    step();
    check_eq("t5_resume_addr", imem_addr, a0);
    repeat (6) step();

    // Counters after sequential run with two redirects
    for (int i = 0; i < 12; i++) begin
      t_pc_src = (i == 4 || i == 9);
      t_branch = 32'h400 + 32'(i) * 32'h40;
      step();
    end
    t_pc_src = 1'b0;
    repeat (3) step();
    check_perf("t6");

    // Reset mid-WAIT; late response lands after reset and is ignored
    mem_delay = 3;
    step();
    mem_delay = 1;
    t_reset = 1'b1;
    repeat (2) step();
    check_reset_outputs("t6_rst");
    t_reset = 1'b0; t_ready = 1'b0;
    step();
    check_eq("t6_req_after_rst", imem_req, 1);
    check_eq("t6_valid_after_rst", IF_ID_valid, 0);
    t_ready = 1'b1;
    repeat (8) step();
    check_eq("t6_sb_level", 32'(sb_q.size() <= 1), 1);
    check_eq("t6_pops", 32'(n_pop >= 5), 1);
    check_perf("t6_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
